// File: rtl/prog_loader.sv
// prog_loader: UART boot loader. Receives a length-prefixed stream of 16-bit
// words (high byte first) and writes them to instruction memory from address 0,
// holding the core idle while the image is being loaded.
module prog_loader #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DEPTH        = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rxd,
   input  logic        load_en,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_data,
   output logic        mem_wren,
   output logic        cpu_hold,
   output logic        done,
   output logic        err,
   output logic [15:0] word_cnt
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [16:0]      DEPTH_W   = 17'(DEPTH);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   typedef enum logic [2:0] {
      L_IDLE, L_LEN_H, L_LEN_L, L_DATA_H, L_DATA_L, L_WRITE, L_DONE
   } l_state_t;

   // ---------------------------------------------------------------------
   // RX front end
   // ---------------------------------------------------------------------
   logic             rx_meta_q, rx_sync_q, rx_prev_q;
   rx_state_t        rx_state_q, rx_state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       rx_byte_q, rx_byte_d;
   logic             byte_valid_q, byte_valid_d;
   logic             frame_err_q, frame_err_d;

   // Synchronize rxd; rx_prev_q keeps the previous synchronized value for edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: synchronizer flops reset to the idle line level so that
         // leaving reset never looks like a start-bit falling edge.
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= rxd;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   // Receiver next-state: mid-bit sampling of start, 8 data bits (LSB first) and stop.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path can
      // leave it unassigned and infer a latch.
      rx_state_d   = rx_state_q;
      cnt_d        = cnt_q;
      bit_d        = bit_q;
      shift_d      = shift_q;
      rx_byte_d    = rx_byte_q;
      byte_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      unique case (rx_state_q)
         RX_IDLE: begin
            if (rx_prev_q && !rx_sync_q) begin
               rx_state_d = RX_START;
               cnt_d      = '0;
            end
         end
         RX_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d      = '0;
               bit_d      = '0;
               // A line already back high is a glitch, not a start bit.
               rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (cnt_q == FULL_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_sync_q, shift_q[7:1]};
               if (bit_q == 3'd7) rx_state_d = RX_STOP;
               else               bit_d      = bit_q + 3'd1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (cnt_q == FULL_LAST) begin
               cnt_d      = '0;
               rx_state_d = RX_IDLE;
               if (rx_sync_q) begin
                  byte_valid_d = 1'b1;
                  rx_byte_d    = shift_q;
               end else begin
                  frame_err_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // Receiver state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_state_q   <= RX_IDLE;
         cnt_q        <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         rx_byte_q    <= '0;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples the pre-edge values regardless of statement order.
         rx_state_q   <= rx_state_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         rx_byte_q    <= rx_byte_d;
         byte_valid_q <= byte_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   // ---------------------------------------------------------------------
   // Loader FSM
   // ---------------------------------------------------------------------
   l_state_t    l_state_q, l_state_d;
   logic [15:0] len_q, len_d;
   logic [7:0]  hi_q, hi_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic [15:0] mem_data_q, mem_data_d;
   logic        mem_wren_q, mem_wren_d;
   logic        cpu_hold_q, cpu_hold_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [15:0] word_cnt_q, word_cnt_d;
   logic [15:0] len_new;
   logic        abort;

   // Loader next-state: header parse, word assembly, write strobe and abort handling.
   always_comb begin
      l_state_d  = l_state_q;
      len_d      = len_q;
      hi_d       = hi_q;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      mem_wren_d = 1'b0;
      cpu_hold_d = cpu_hold_q;
      done_d     = done_q;
      err_d      = err_q;
      word_cnt_d = word_cnt_q;
      len_new    = {len_q[15:8], rx_byte_q};

      // A framing error mid-stream and load_en dropping mid-load collapse
      // into one abort, so coincident events still give a single err.
      abort = ((l_state_q != L_IDLE) && frame_err_q) || (cpu_hold_q && !load_en);

      if (abort) begin
         err_d      = 1'b1;
         cpu_hold_d = 1'b0;
         l_state_d  = L_IDLE;
      end else begin
         unique case (l_state_q)
            L_IDLE: begin
               if (load_en && byte_valid_q) begin
                  len_d[15:8] = rx_byte_q;
                  done_d      = 1'b0;
                  err_d       = 1'b0;
                  word_cnt_d  = '0;
                  cpu_hold_d  = 1'b1;
                  l_state_d   = L_LEN_L;
               end
            end
            L_LEN_L: begin
               if (byte_valid_q) begin
                  len_d = len_new;
                  if (len_new == 16'd0) begin
                     l_state_d = L_DONE;
                  end else if ({1'b0, len_new} > DEPTH_W) begin
                     err_d      = 1'b1;
                     cpu_hold_d = 1'b0;
                     l_state_d  = L_IDLE;
                  end else begin
                     mem_addr_d = '0;
                     l_state_d  = L_DATA_H;
                  end
               end
            end
            L_DATA_H: begin
               if (byte_valid_q) begin
                  hi_d      = rx_byte_q;
                  l_state_d = L_DATA_L;
               end
            end
            L_DATA_L: begin
               if (byte_valid_q) begin
                  // Address equals the count of words already written; it is
                  // updated here so it stays put through and after the strobe.
                  mem_data_d = {hi_q, rx_byte_q};
                  mem_addr_d = word_cnt_q;
                  mem_wren_d = 1'b1;
                  l_state_d  = L_WRITE;
               end
            end
            L_WRITE: begin
               word_cnt_d = word_cnt_q + 16'd1;
               if (word_cnt_q + 16'd1 == len_q) begin
                  done_d     = 1'b1;
                  cpu_hold_d = 1'b0;
                  l_state_d  = L_DONE;
               end else begin
                  l_state_d  = L_DATA_H;
               end
            end
            L_DONE: begin
               done_d     = 1'b1;
               cpu_hold_d = 1'b0;
               l_state_d  = L_IDLE;
            end
            default: l_state_d = L_IDLE;
         endcase
      end
   end

   // Loader state and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         l_state_q  <= L_IDLE;
         len_q      <= '0;
         hi_q       <= '0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
         mem_wren_q <= 1'b0;
         cpu_hold_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         word_cnt_q <= '0;
      end else begin
         l_state_q  <= l_state_d;
         len_q      <= len_d;
         hi_q       <= hi_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
         mem_wren_q <= mem_wren_d;
         cpu_hold_q <= cpu_hold_d;
         done_q     <= done_d;
         err_q      <= err_d;
         word_cnt_q <= word_cnt_d;
      end
   end

   assign mem_addr = mem_addr_q;
   assign mem_data = mem_data_q;
   assign mem_wren = mem_wren_q;
   assign cpu_hold = cpu_hold_q;
   assign done     = done_q;
   assign err      = err_q;
   assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed bench for prog_loader with a fast UART bit time.
module tb_prog_loader;

   localparam int CPB   = 4;
   localparam int DEPTH = 4096;

   logic        clk = 1'b0;
   logic        rst;
   logic        rxd;
   logic        load_en;
   logic [15:0] mem_addr;
   logic [15:0] mem_data;
   logic        mem_wren;
   logic        cpu_hold;
   logic        done;
   logic        err;
   logic [15:0] word_cnt;

   int checks = 0;
   int errors = 0;

   // write log captured from the strobe
   int          n_wr = 0;
   logic [15:0] wr_addr [0:15];
   logic [15:0] wr_data [0:15];
   logic        wren_prev = 1'b0;
   int          wren_long = 0;

   prog_loader #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .rxd      (rxd),
      .load_en  (load_en),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
      .mem_wren (mem_wren),
      .cpu_hold (cpu_hold),
      .done     (done),
      .err      (err),
      .word_cnt (word_cnt)
   );

   always #5 clk = ~clk;

   // Log every write and flag any strobe wider than one cycle.
   always @(negedge clk) begin
      if (rst && mem_wren) begin
         if (n_wr < 16) begin
            wr_addr[n_wr] = mem_addr;
            wr_data[n_wr] = mem_data;
         end
         n_wr = n_wr + 1;
         if (wren_prev) wren_long = wren_long + 1;
      end
      wren_prev = rst && mem_wren;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // One UART frame, no idle time after it.
   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      logic [9:0] frame;
      frame = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rxd = frame[i];
         cycles(CPB);
      end
      rxd = 1'b1;
   endtask

   task automatic send_word(input logic [15:0] w);
      send_byte(w[15:8], 1'b1);
      send_byte(w[7:0], 1'b1);
   endtask

   initial begin
      rst     = 1'b0;
      rxd     = 1'b1;
      load_en = 1'b0;
      cycles(3);
      check("rst_addr",  mem_addr, 16'h0);
      check("rst_data",  mem_data, 16'h0);
      check("rst_wren",  mem_wren, 1'b0);
      check("rst_hold",  cpu_hold, 1'b0);
      check("rst_flags", {done, err}, 2'b00);
      check("rst_cnt",   word_cnt, 16'h0);
      rst = 1'b1;
      cycles(3);
      load_en = 1'b1;

      // 1: two-word image, back-to-back bytes
      n_wr = 0;
      send_byte(8'h00, 1'b1);
      cycles(6);
      check("t1_hold_hi", cpu_hold, 1'b1);
      send_byte(8'h02, 1'b1);
      send_word(16'h1234);
      send_word(16'hABCD);
      cycles(12);
      check("t1_nwr",   n_wr, 2);
      check("t1_a0",    wr_addr[0], 16'h0000);
      check("t1_d0",    wr_data[0], 16'h1234);
      check("t1_a1",    wr_addr[1], 16'h0001);
      check("t1_d1",    wr_data[1], 16'hABCD);
      check("t1_cnt",   word_cnt, 16'd2);
      check("t1_flags", {done, err, cpu_hold}, 3'b100);

      // 2: empty image
      n_wr = 0;
      send_word(16'h0000);
      cycles(12);
      check("t2_nwr",   n_wr, 0);
      check("t2_flags", {done, err, cpu_hold}, 3'b100);
      check("t2_cnt",   word_cnt, 16'd0);

      // 3: length beyond memory depth
      n_wr = 0;
      send_word(16'h1001);
      cycles(12);
      check("t3_nwr",   n_wr, 0);
      check("t3_flags", {done, err, cpu_hold}, 3'b010);

      // 4: framing error after one word, then a clean recovery load
      n_wr = 0;
      send_word(16'h0003);
      send_word(16'h1122);
      send_byte(8'h33, 1'b0);
      cycles(12);
      check("t4_nwr",   n_wr, 1);
      check("t4_a0",    wr_addr[0], 16'h0000);
      check("t4_d0",    wr_data[0], 16'h1122);
      check("t4_flags", {done, err, cpu_hold}, 3'b010);
      check("t4_cnt",   word_cnt, 16'd1);
      n_wr = 0;
      send_word(16'h0001);
      send_word(16'h5566);
      cycles(12);
      check("t4r_nwr",   n_wr, 1);
      check("t4r_d0",    wr_data[0], 16'h5566);
      check("t4r_flags", {done, err, cpu_hold}, 3'b100);

      // 5: single-cycle glitch must not produce a byte
      n_wr = 0;
      rxd = 1'b0;
      cycles(1);
      rxd = 1'b1;
      cycles(40);
      check("t5_nwr",   n_wr, 0);
      check("t5_flags", {done, err, cpu_hold}, 3'b100);
      check("t5_cnt",   word_cnt, 16'd1);
      send_word(16'h0001);
      send_word(16'h7788);
      cycles(12);
      check("t5_align", {n_wr[15:0], wr_data[0]}, {16'd1, 16'h7788});
      check("t5_done",  {done, err}, 2'b10);

      // 6a: load_en dropped mid-payload
      n_wr = 0;
      send_word(16'h0002);
      send_word(16'h99AA);
      send_byte(8'hBB, 1'b1);
      cycles(6);
      check("t6a_hold_mid", cpu_hold, 1'b1);
      load_en = 1'b0;
      cycles(3);
      check("t6a_flags", {done, err, cpu_hold}, 3'b010);
      check("t6a_nwr",   n_wr, 1);
      load_en = 1'b1;
      cycles(3);

      // 6b: reset mid-payload
      n_wr = 0;
      send_word(16'h0002);
      send_word(16'h1234);
      send_byte(8'h56, 1'b1);
      cycles(6);
      check("t6b_hold_mid", cpu_hold, 1'b1);
      rst = 1'b0;
      cycles(1);
      check("t6b_outs", {mem_addr, mem_data, mem_wren, cpu_hold, done, err, word_cnt},
            {16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0});
      rst = 1'b1;
      cycles(3);

      check("wren_width", wren_long, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
